mips_cpu_hilo_seq: RTL
======================

# mips_cpu_hilo_seq

Multi-cycle sequencer for MULT, MULTU, DIV and DIVU that owns the architectural HI/LO registers. It sits between the decode/execute stage and the shared ALU. For each operation it drives two ALU passes: the HI-result code first, then the LO-result code. Each pass is held for a fixed number of cycles to cover the long multiply/divide combinational path. HI and LO are committed together at the end. The block stalls the pipeline via `busy`, handles MTHI/MTLO writes, and traps divide-by-zero before the ALU ever sees a zero divisor.

## Interface
- `PASS_CYCLES`, default 2: cycles each ALU pass is held before its result is captured; legal range 1–15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  operand a (dividend / multiplicand).
- `rt_val`  in  32  operand b (divisor / multiplier).
- `mthi`  in  1  write `wdata` to HI; honoured only in IDLE.
- `mtlo`  in  1  write `wdata` to LO; honoured only in IDLE.
- `wdata`  in  32  MTHI/MTLO data.
- `alu_out`  in  32  result from the shared ALU.
- `alu_a`  out  32  ALU operand a.
- `alu_b`  out  32  ALU operand b.
- `alu_ctrl`  out  4  ALU operation code.
- `busy`  out  1  high while a pass is in progress (stall request).
- `done`  out  1  one-cycle pulse on completion, including the divide-by-zero case.
- `div0`  out  1  one-cycle pulse for DIV/DIVU with `rt_val`==0.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- **FSM states:** IDLE, PASS_HI, PASS_LO. A 4-bit down-counter `cnt` times each pass.
- **Start in IDLE:**
  - Latch `rs_val`, `rt_val` and `op` into internal registers `opa`, `opb`, `opr`.
  - If `op`[1]==1 and `rt_val`==0: stay in IDLE and pulse `div0` and `done` next cycle; HI/LO unchanged.
  - Otherwise: go to PASS_HI with `cnt`=`PASS_CYCLES`-1.
- **Pass codes (HI pass, then LO pass):**
  - MULT: 1001, then 1000.
  - MULTU: 1011, then 1010.
  - DIV: 1101 (remainder → HI), then 1100 (quotient → LO).
  - DIVU: 1111, then 1110.
- **During PASS_HI / PASS_LO:** `alu_a`=`opa`, `alu_b`=`opb`, `alu_ctrl`=the pass code. Changes on `rs_val`/`rt_val` have no effect.
- **Counter:** `cnt` decrements each cycle. At `cnt`==0:
  - In PASS_HI: capture `alu_out` into shadow register `hi_tmp`, reload `cnt`, go to PASS_LO.
  - In PASS_LO: `hi`<=`hi_tmp`, `lo`<=`alu_out`, `done`<=1, go to IDLE.
- **In IDLE:** `alu_a`=`alu_b`=0, `alu_ctrl`=0000.
- **Commit rule:** HI and LO are never updated separately by an operation; the shadow register guarantees an atomic commit.
- **MTHI/MTLO in IDLE:**
  - Either may be asserted alone; both together write `wdata` to both registers.
  - Same cycle as `start`: the write takes effect, then the operation's commit overwrites it.
- **Requests while busy:** `start`, `mthi` and `mtlo` asserted while `busy`==1 are ignored; they are not queued.
- **Arithmetic:** the block performs none itself. The ALU's signed rules apply: quotient negated on sign mismatch, remainder takes the sign of the dividend.

## Timing
- **Reset values:** state IDLE, `hi`=`lo`=`hi_tmp`=0, `busy`=`done`=`div0`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=0000.
- **Latency:** with `start` sampled at edge 0:
  - PASS_HI occupies cycles 1..P and PASS_LO occupies cycles P+1..2P, where P=`PASS_CYCLES`.
  - `busy` is high in cycles 1..2P.
  - `done` is high in cycle 2P+1, with new `hi`/`lo` visible in that cycle.
- **Back-to-back:** `done` cycle is IDLE, so a new `start` is accepted in it. Minimum issue interval is 2P+1 cycles.
- **Divide-by-zero:** `div0`=`done`=1 in cycle 1, `busy` stays 0, ALU outputs stay idle.
- **Reset mid-operation:** aborts immediately; no `done`, and `hi`/`lo` go to 0.
- **`busy` encoding:** `busy` is a combinational decode of state≠IDLE. `done` and `div0` are registered.

## Test plan
- **MULT, P=2:** `rs_val`=FFFFFFFE, `rt_val`=00000003 → `busy` in cycles 1–4, `alu_ctrl` 1001 then 1000, `done` in cycle 5, `hi`=FFFFFFFF, `lo`=FFFFFFFA.
- **MULTU, same operands:** `hi`=00000002, `lo`=FFFFFFFA. Then DIV FFFFFFF9/00000002 → `lo`=FFFFFFFD, `hi`=FFFFFFFF. Then DIVU 7/2 → `lo`=3, `hi`=1.
- **DIV with `rt_val`=0, `hi`/`lo` preloaded to 11111111/22222222:** `div0` and `done` pulse in cycle 1, `busy` never high, `alu_ctrl` stays 0000, `hi`/`lo` unchanged.
- **Ignored requests:** during MULT, assert `start` (DIVU), `mthi` and changing `rs_val` → all ignored; result still matches the original operands. `start` in the `done` cycle → accepted.
- **MTHI/MTLO in IDLE:** `mthi` with `wdata`=CAFEF00D → `hi` updates next cycle, `lo` unchanged. `mthi`+`mtlo` with `wdata`=5 → both equal 5.
- **Reset mid-pass:** assert `reset` in cycle 3 of a MULT → next cycle IDLE, `hi`=`lo`=0, no `done`. Repeat with P=1: `done` in cycle 3.

Source files
------------

// File: rtl/mips_cpu_hilo_seq.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: sequences two timed passes through the shared ALU
// (HI code, then LO code) and commits both halves atomically; traps divide-by-zero up front.
module mips_cpu_hilo_seq #(
  parameter int unsigned PASS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] alu_out,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS_HI = 2'd1,
    PASS_LO = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(PASS_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [1:0]  opr_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_tmp_q;
  logic        done_q;
  logic        div0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      opr_q    <= 2'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            opa_q <= rs_val;
            opb_q <= rt_val;
            opr_q <= op;
            // A zero divisor never reaches the ALU; report it and stay idle.
            if (op[1] && (rt_val == 32'd0)) begin
              done_q <= 1'b1;
              div0_q <= 1'b1;
            end else begin
              state_q <= PASS_HI;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        PASS_HI: begin
          if (cnt_q == 4'd0) begin
            hi_tmp_q <= alu_out;
            cnt_q    <= CNT_LOAD;
            state_q  <= PASS_LO;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        PASS_LO: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= hi_tmp_q;
            lo_q    <= alu_out;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pass code is 1,op,sel where sel=1 selects the HI-result flavour.
  assign busy     = (state_q != IDLE);
  assign alu_a    = busy ? opa_q : 32'd0;
  assign alu_b    = busy ? opb_q : 32'd0;
  assign alu_ctrl = busy ? {1'b1, opr_q, (state_q == PASS_HI)} : 4'b0000;
  assign done     = done_q;
  assign div0     = div0_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
